alu_op_dispatcher: RTL and testbench

- Parametrised operand-collection and operation-dispatch engine for the calculator datapath.
- Accepts operands over a valid/ready stream and selects one of NUM_OPS operation units by op code.
- Issues a one-cycle one-hot start to that unit, waits for its done, then captures and holds the result until acknowledged.
- Over the previous fixed-width, stuck-after-output controller it adds: arbitrary width and op count, a per-op arity mask, result chaining, abort and result acknowledge.

---
 rtl/alu_op_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_alu_op_dispatcher.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_dispatcher.sv
// Operand collection and one-hot op dispatch with result hold/ack.
// Optional WAIT watchdog: define ALU_OP_DISPATCHER_TIMEOUT_EN.
module alu_op_dispatcher #(
  parameter int W = 16,
  parameter int NUM_OPS = 16,
  parameter int OPW = 4,
  parameter logic [NUM_OPS-1:0] TWO_OP_MASK = 16'h3C0F,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic [OPW-1:0]     op_sel,
  input  logic               use_prev,
  input  logic               operand_valid,
  input  logic [W-1:0]       operand_data,
  output logic               operand_ready,
  output logic [NUM_OPS-1:0] unit_start,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  input  logic [NUM_OPS-1:0] unit_done,
  input  logic [NUM_OPS*W-1:0] unit_result,
  input  logic [NUM_OPS-1:0] unit_error,
  output logic [W-1:0]       result,
  output logic               error,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               busy
);

  if (((1 << OPW) < NUM_OPS) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("alu_op_dispatcher: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE,
    GET_B,
    START,
    WAIT,
    HOLD
  } state_t;

  localparam int NSEL = 1 << OPW;

  state_t state, nxt;

  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           err_q;
  logic [W-1:0]   last_q;

  logic [NSEL-1:0] mask_x;
  logic            in_range;
  logic            xfer;
  logic            sel_done;
  logic            sel_err;
  logic [W-1:0]    sel_res;
  logic            cnt_hit;

  logic ld_a, ld_b, clr_b, cap, bad_op, tmo;

  assign xfer     = operand_valid && operand_ready;
  assign in_range = {1'b0, op_sel} < (OPW+1)'(NUM_OPS);

  always_comb begin
    mask_x = '0;
    mask_x[NUM_OPS-1:0] = TWO_OP_MASK;
  end

  // Only the selected unit's done/result/error are ever visible.
  always_comb begin
    sel_done = 1'b0;
    sel_err  = 1'b0;
    sel_res  = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (op_q == OPW'(i)) begin
        sel_done = unit_done[i];
        sel_err  = unit_error[i];
        sel_res  = unit_result[i*W +: W];
      end
    end
  end

`ifdef ALU_OP_DISPATCHER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cnt_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign cnt_hit = 1'b0;
`endif

  always_comb begin
    nxt    = state;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    clr_b  = 1'b0;
    cap    = 1'b0;
    bad_op = 1'b0;
    tmo    = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          ld_a = 1'b1;
          if (!in_range) begin
            bad_op = 1'b1;
            nxt    = HOLD;
          end else if (mask_x[op_sel]) begin
            nxt = GET_B;
          end else begin
            clr_b = 1'b1;
            nxt   = START;
          end
        end
      end
      GET_B: begin
        if (xfer) begin
          ld_b = 1'b1;
          nxt  = START;
        end
      end
      START: nxt = WAIT;
      WAIT: begin
        if (sel_done) begin
          cap = 1'b1;
          nxt = HOLD;
        end else if (cnt_hit) begin
          tmo = 1'b1;
          nxt = HOLD;
        end
      end
      HOLD: begin
        if (result_ack) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt    = IDLE;
      ld_a   = 1'b0;
      ld_b   = 1'b0;
      clr_b  = 1'b0;
      cap    = 1'b0;
      bad_op = 1'b0;
      tmo    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      last_q <= '0;
    end else begin
      if (ld_a) begin
        op_q <= op_sel;
        a_q  <= use_prev ? last_q : operand_data;
      end
      if (ld_b) b_q <= operand_data;
      if (clr_b) b_q <= '0;
      if (bad_op) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
      if (cap) begin
        res_q <= sel_res;
        err_q <= sel_err;
        if (!sel_err) last_q <= sel_res;
      end
      if (tmo) begin
        res_q <= '1;
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    unit_start = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      unit_start[i] = (state == START) && !abort && (op_q == OPW'(i));
    end
  end

  assign operand_ready = (state == IDLE) || (state == GET_B);
  assign busy          = (state != IDLE);
  assign result_valid  = (state == HOLD);
  assign unit_a        = a_q;
  assign unit_b        = b_q;
  assign result        = res_q;
  assign error         = err_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Randomized bench for alu_op_dispatcher with a transaction-level model.
module tb_alu_op_dispatcher;
  localparam int W = 16;
  localparam int NUM_OPS = 12;
  localparam int OPW = 4;
  localparam logic [NUM_OPS-1:0] MASK = 12'hC0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic [OPW-1:0] op_sel = '0;
  logic use_prev = 1'b0;
  logic operand_valid = 1'b0;
  logic [W-1:0] operand_data = '0;
  logic operand_ready;
  logic [NUM_OPS-1:0] unit_start;
  logic [W-1:0] unit_a, unit_b;
  logic [NUM_OPS-1:0] unit_done = '0;
  logic [NUM_OPS*W-1:0] unit_result = '0;
  logic [NUM_OPS-1:0] unit_error = '0;
  logic [W-1:0] result;
  logic error;
  logic result_valid;
  logic result_ack = 1'b0;
  logic busy;

  alu_op_dispatcher #(
    .W(W), .NUM_OPS(NUM_OPS), .OPW(OPW),
    .TWO_OP_MASK(MASK), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .op_sel(op_sel), .use_prev(use_prev),
    .operand_valid(operand_valid),
    .operand_data(operand_data),
    .operand_ready(operand_ready),
    .unit_start(unit_start),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done),
    .unit_result(unit_result),
    .unit_error(unit_error),
    .result(result), .error(error),
    .result_valid(result_valid),
    .result_ack(result_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] last_m = '0;
  logic [W-1:0] res_m = '0;
  logic err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_results;
    for (int i = 0; i < NUM_OPS; i++)
      unit_result[i*W +: W] = W'($urandom);
  endtask

  // mode: 0 normal, 1 stray done, 2 done in start,
  // 3 abort in wait, 4 reset in get_b, 5 abort in start
  task automatic run_op(input int op, input bit up,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input bit uerr, input int mode);
    logic [W-1:0] exp_a, exp_b, exp_r;
    bit two, bad;
    int other;
    bad = (op >= NUM_OPS);
    two = bad ? 1'b0 : MASK[op];
    exp_a = up ? last_m : a;
    exp_b = two ? b : '0;
    chk("idle_ready", operand_ready, 1);
    chk("idle_busy", busy, 0);
    chk("held_result", result, res_m);
    chk("held_error", error, err_m);
    operand_valid = 1'b1;
    op_sel = OPW'(op);
    use_prev = up;
    operand_data = a;
    tick;
    operand_valid = 1'b0;
    use_prev = 1'b0;
    if (bad) begin
      chk("bad_valid", result_valid, 1);
      chk("bad_err", error, 1);
      chk("bad_res", result, 0);
      chk("bad_start", unit_start, 0);
      res_m = '0;
      err_m = 1'b1;
      tick;
      chk("bad_start2", unit_start, 0);
      chk("bad_hold", result_valid, 1);
      result_ack = 1'b1;
      tick;
      result_ack = 1'b0;
      chk("bad_ack", result_valid, 0);
      return;
    end
    if (two) begin
      chk("getb_ready", operand_ready, 1);
      chk("getb_start", unit_start, 0);
      chk("getb_busy", busy, 1);
      if (mode == 4) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", operand_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_a", unit_a, 0);
        chk("rst_b", unit_b, 0);
        chk("rst_res", result, 0);
        chk("rst_err", error, 0);
        chk("rst_rv", result_valid, 0);
        rst = 1'b0;
        last_m = '0;
        res_m = '0;
        err_m = 1'b0;
        tick;
        return;
      end
      operand_valid = 1'b1;
      operand_data = b;
      use_prev = 1'($urandom);
      tick;
      operand_valid = 1'b0;
      use_prev = 1'b0;
    end
    chk("start_ready", operand_ready, 0);
    chk("start_onehot", unit_start, 1 << op);
    chk("unit_a", unit_a, exp_a);
    chk("unit_b", unit_b, exp_b);
    if (mode == 5) begin
      abort = 1'b1;
      #1;
      chk("abort_start", unit_start, 0);
      tick;
      abort = 1'b0;
      chk("abort_s_busy", busy, 0);
      chk("abort_s_rv", result_valid, 0);
      return;
    end
    if (mode == 2) begin
      fill_results;
      unit_done = NUM_OPS'(1 << op);
      unit_error = '1;
    end
    tick;
    unit_done = '0;
    unit_error = '0;
    chk("wait_start_clr", unit_start, 0);
    chk("wait_rv", result_valid, 0);
    for (int i = 0; i < lat; i++) begin
      if (mode == 1 && i == 0) begin
        other = (op + 1 + $urandom_range(0, NUM_OPS - 2)) % NUM_OPS;
        fill_results;
        unit_done = NUM_OPS'(1 << other);
      end
      tick;
      unit_done = '0;
      chk("wait_stray", result_valid, 0);
    end
    if (mode == 3) begin
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_rv", result_valid, 0);
      chk("abort_res", result, res_m);
      chk("abort_err", error, err_m);
      fill_results;
      unit_done = NUM_OPS'(1 << op);
      tick;
      unit_done = '0;
      chk("late_done_rv", result_valid, 0);
      chk("late_done_busy", busy, 0);
      return;
    end
    fill_results;
    exp_r = unit_result[op*W +: W];
    unit_error = NUM_OPS'($urandom);
    unit_error[op] = uerr;
    unit_done = NUM_OPS'(1 << op);
    tick;
    unit_done = '0;
    unit_error = '0;
    chk("cap_rv", result_valid, 1);
    chk("cap_res", result, exp_r);
    chk("cap_err", error, uerr);
    res_m = exp_r;
    err_m = uerr;
    if (!uerr) last_m = exp_r;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      if (i == 0) begin
        fill_results;
        unit_done = NUM_OPS'(1 << op);
      end
      tick;
      unit_done = '0;
      chk("hold_rv", result_valid, 1);
      chk("hold_res", result, res_m);
    end
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
    chk("ack_rv", result_valid, 0);
    chk("ack_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int op, lat, mode;
    #3;
    chk("reset_ready", operand_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_start", unit_start, 0);
    chk("reset_a", unit_a, 0);
    chk("reset_b", unit_b, 0);
    chk("reset_res", result, 0);
    chk("reset_err", error, 0);
    chk("reset_rv", result_valid, 0);
    #4 rst = 1'b0;
    tick;
    run_op(0, 0, 16'h0003, 16'h0004, 5, 0, 0);
    run_op(2, 1, 16'hFFFF, 16'h1234, 1, 0, 0);
    run_op(4, 0, 16'h0010, 16'hBEEF, 2, 1, 0);
    run_op(3, 0, 16'h0055, 16'h00AA, 3, 0, 1);
    run_op(5, 0, 16'h0101, 16'h0000, 2, 0, 2);
    run_op(6, 0, 16'h0202, 16'h0000, 2, 0, 3);
    run_op(1, 0, 16'h0303, 16'h0404, 2, 0, 4);
    run_op(7, 0, 16'h0505, 16'h0000, 2, 0, 5);
    run_op(13, 0, 16'h0606, 16'h0000, 0, 0, 0);
    run_op(4, 0, 16'h0000, 16'h0000, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 15);
      lat = $urandom_range(0, 6);
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      if (mode == 1 && lat == 0) lat = 1;
      run_op(op, 1'($urandom), W'($urandom), W'($urandom),
             lat, ($urandom_range(0, 3) == 0), mode);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
